// File: rtl/ts_ram_ctrl.sv
// Strobe-protocol master for the clockless time-shared RAM.
// Turns valid/ready requests into read-level / write-edge cycles on a shared bus.
module ts_ram_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_read,
    output logic              ram_write,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam int MAXC = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                oe_q;
    logic                read_q;
    logic                write_q;
    logic                rsp_valid_q;

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign ram_addr  = addr_q;
    assign ram_read  = read_q;
    assign ram_write = write_q;
    assign ram_data  = oe_q ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            oe_q        <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        cnt_q  <= S_LD;
                        if (req_we) begin
                            wdata_q <= req_wdata;
                            oe_q    <= 1'b1;
                            state_q <= WR_SETUP;
                        end else begin
                            read_q  <= 1'b1;
                            state_q <= RD_SETUP;
                        end
                    end
                end
                RD_SETUP: begin
                    if (cnt_q == '0) begin
                        // RAM drives the bus while read is high; capture before dropping it
                        rdata_q     <= ram_data;
                        rsp_valid_q <= 1'b1;
                        read_q      <= 1'b0;
                        state_q     <= RD_DONE;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                RD_DONE: begin
                    state_q <= IDLE;
                end
                WR_SETUP: begin
                    if (cnt_q == '0) begin
                        write_q <= 1'b1;
                        cnt_q   <= P_LD;
                        state_q <= WR_PULSE;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                WR_PULSE: begin
                    if (cnt_q == '0) begin
                        write_q <= 1'b0;
                        state_q <= WR_HOLD;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                WR_HOLD: begin
                    // data was held one cycle past the falling strobe
                    oe_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ts_ram_ctrl.sv
// Bench for ts_ram_ctrl: two instances (S=1/P=1 and S=2/P=3) each on a RAM model.
// Directed table, hand sequences for reset/back-to-back, then random traffic.
module tb_ts_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = '0;
    logic [3:0] req_wdata = '0;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    logic       v1, v2;
    logic       rdy1, rdy2, rv1, rv2, rr1, rr2, rw1, rw2;
    logic [3:0] rd1, rd2, ra1, ra2;
    wire  [3:0] bus1, bus2;

    assign v1 = req_valid & ~sel;
    assign v2 = req_valid & sel;

    ts_ram_ctrl #(.ADDR_W(4), .DATA_W(4), .SETUP_CYC(1), .PULSE_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1),
        .ram_addr(ra1), .ram_read(rr1), .ram_write(rw1), .ram_data(bus1)
    );

    ts_ram_ctrl #(.ADDR_W(4), .DATA_W(4), .SETUP_CYC(2), .PULSE_CYC(3)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_rdata(rd2),
        .ram_addr(ra2), .ram_read(rr2), .ram_write(rw2), .ram_data(bus2)
    );

    // Clockless RAM models: level read drives the bus, write commits on rising edge
    logic [3:0] mem1 [16];
    logic [3:0] mem2 [16];
    int         edges1 = 0;
    int         edges2 = 0;

    assign bus1 = rr1 ? mem1[ra1] : 4'bzzzz;
    assign bus2 = rr2 ? mem2[ra2] : 4'bzzzz;

    initial begin
        for (int i = 0; i < 16; i++) mem1[i] = 4'((i * 3) % 16);
        forever begin
            @(posedge rw1);
            mem1[ra1] = bus1;
            edges1++;
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem2[i] = 4'((i * 3) % 16);
        forever begin
            @(posedge rw2);
            mem2[ra2] = bus2;
            edges2++;
        end
    end

    logic       s_rdy, s_rv, s_rr, s_rw;
    logic [3:0] s_rd, s_ra, s_bus;

    always_comb begin
        s_rdy = sel ? rdy2 : rdy1;
        s_rv  = sel ? rv2  : rv1;
        s_rr  = sel ? rr2  : rr1;
        s_rw  = sel ? rw2  : rw1;
        s_rd  = sel ? rd2  : rd1;
        s_ra  = sel ? ra2  : ra1;
        s_bus = sel ? bus2 : bus1;
    end

    // Reference model: expected memory image and write count per instance
    logic [3:0] refm [2][16];
    int         ew [2];
    int         vecs = 0;
    int         fails = 0;

    typedef struct {
        bit         d;
        bit         we;
        logic [3:0] a;
        logic [3:0] wd;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // undriven bus reads as z on 4-state simulators and 0 on 2-state ones
    function automatic logic idle_bus(input logic [3:0] b);
        return (b === 4'bzzzz) || (b === 4'b0000);
    endfunction

    task automatic txn(input bit d, input bit we, input logic [3:0] a, input logic [3:0] wd);
        int s;
        int p;
        int n;
        int last;
        s = d ? 2 : 1;
        p = d ? 3 : 1;
        @(negedge clk);
        sel = d;
        #1;
        n = 0;
        while (!s_rdy && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ready_before_req", s_rdy, 1);
        if (!s_rdy) return;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (we) begin
            refm[d][a] = wd;
            ew[d]++;
        end
        last = we ? s + p + 2 : s + 2;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (!we) begin
                chk("rd_read_level", s_rr, k <= s);
                chk("rd_rsp_valid", s_rv, k == s + 1);
                chk("rd_ready", s_rdy, k >= s + 2);
                chk("rd_no_strobe", s_rw, 0);
                if (k <= s) begin
                    chk("rd_addr", s_ra, a);
                    chk("rd_bus", s_bus, refm[d][a]);
                end else begin
                    chk("rd_bus_idle", idle_bus(s_bus), 1);
                end
                if (k == s + 1) chk("rd_data", s_rd, refm[d][a]);
            end else begin
                chk("wr_no_read", s_rr, 0);
                chk("wr_strobe", s_rw, (k >= s + 1) && (k <= s + p));
                chk("wr_rsp_quiet", s_rv, 0);
                chk("wr_ready", s_rdy, k >= s + p + 2);
                if (k <= s + p + 1) chk("wr_bus_driven", s_bus, wd);
                else chk("wr_bus_released", idle_bus(s_bus), 1);
                chk("wr_addr", s_ra, a);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready1"}, rdy1, 0);
        chk({tag, "_ready2"}, rdy2, 0);
        chk({tag, "_read"}, {rr1, rr2}, 0);
        chk({tag, "_write"}, {rw1, rw2}, 0);
        chk({tag, "_rsp"}, {rv1, rv2}, 0);
        chk({tag, "_rdata"}, {rd1, rd2}, 0);
        chk({tag, "_addr"}, {ra1, ra2}, 0);
        chk({tag, "_bus1"}, idle_bus(bus1), 1);
        chk({tag, "_bus2"}, idle_bus(bus2), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            refm[0][i] = 4'((i * 3) % 16);
            refm[1][i] = 4'((i * 3) % 16);
        end
        ew[0] = 0;
        ew[1] = 0;

        tbl[0] = '{1'b0, 1'b0, 4'h2, 4'h0, 4'h6};
        tbl[1] = '{1'b0, 1'b1, 4'h3, 4'hA, 4'h0};
        tbl[2] = '{1'b0, 1'b0, 4'h3, 4'h0, 4'hA};
        tbl[3] = '{1'b1, 1'b1, 4'h4, 4'h7, 4'h0};
        tbl[4] = '{1'b1, 1'b0, 4'h4, 4'h0, 4'h7};
        tbl[5] = '{1'b1, 1'b0, 4'h2, 4'h0, 4'h6};
        tbl[6] = '{1'b0, 1'b1, 4'hF, 4'h3, 4'h0};
        tbl[7] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h3};
        tbl[8] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[9] = '{1'b0, 1'b0, 4'h7, 4'h0, 4'h5};

        // reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready1", rdy1, 1);
        chk("post_reset_ready2", rdy2, 1);

        // directed table
        foreach (tbl[i]) begin
            txn(tbl[i].d, tbl[i].we, tbl[i].a, tbl[i].wd);
            if (!tbl[i].we) chk("tbl_rdata", tbl[i].d ? rd2 : rd1, tbl[i].exp);
        end

        // back-to-back read/write/read with req_valid held high
        @(negedge clk);
        sel = 1'b0;
        req_we = 1'b0;
        req_addr = 4'h3;
        req_valid = 1'b1;
        #1;
        chk("b2b_ready0", rdy1, 1);
        @(negedge clk);
        chk("b2b_c1_read", rr1, 1);
        @(negedge clk);
        chk("b2b_c2_rsp", rv1, 1);
        chk("b2b_c2_data", rd1, refm[0][3]);
        chk("b2b_c2_gap", idle_bus(bus1) && !rr1, 1);
        @(negedge clk);
        chk("b2b_c3_ready", rdy1, 1);
        chk("b2b_c3_gap", idle_bus(bus1) && !rr1, 1);
        req_we = 1'b1;
        req_wdata = 4'h9;
        @(negedge clk);
        chk("b2b_c4_noread", rr1, 0);
        chk("b2b_c4_bus", bus1, 4'h9);
        chk("b2b_c4_ready", rdy1, 0);
        @(negedge clk);
        chk("b2b_c5_strobe", rw1, 1);
        req_we = 1'b0;
        @(negedge clk);
        chk("b2b_c6_hold", {rw1, rr1}, 2'b00);
        chk("b2b_c6_bus", bus1, 4'h9);
        @(negedge clk);
        chk("b2b_c7_ready", rdy1, 1);
        chk("b2b_c7_gap", idle_bus(bus1) && !rr1, 1);
        @(negedge clk);
        chk("b2b_c8_read", rr1, 1);
        @(negedge clk);
        chk("b2b_c9_rsp", rv1, 1);
        chk("b2b_c9_data", rd1, 4'h9);
        req_valid = 1'b0;
        refm[0][3] = 4'h9;
        ew[0]++;
        @(negedge clk);

        // reset in cycle 1 of a write: no commit
        @(negedge clk);
        sel = 1'b0;
        req_we = 1'b1;
        req_addr = 4'h5;
        req_wdata = 4'hC;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstw_c1_bus", bus1, 4'hC);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rstw_c2");
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_ready", rdy1, 1);
        chk("rstw_mem", mem1[5], refm[0][5]);
        chk("rstw_edges", edges1, ew[0]);
        txn(1'b0, 1'b0, 4'h5, 4'h0);

        // reset with simultaneous request: never accepted
        @(negedge clk);
        sel = 1'b0;
        rst = 1'b1;
        req_we = 1'b0;
        req_addr = 4'h1;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rstreq_ready1", rdy1, 0);
            chk("rstreq_ready2", rdy2, 0);
            chk("rstreq_read", {rr1, rr2}, 0);
        end
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rstreq_noaccept", {rr1, rr2, rw1, rw2}, 0);

        // random traffic against the reference memory image
        for (int i = 0; i < 60; i++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
        end

        chk("edges_dut1", edges1, ew[0]);
        chk("edges_dut2", edges2, ew[1]);
        for (int i = 0; i < 16; i++) begin
            chk("final_mem1", mem1[i], refm[0][i]);
            chk("final_mem2", mem2[i], refm[1][i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
